board_engine: RTL and testbench
===============================

// Module: board_engine
// PURPOSE
// - Parametrised successor to the 3x3 tic-tac-toe datapath: N x N board, K-in-a-row win rule.
// - Accepts moves over a valid/ready handshake, enforces turn order, returns an error code per move.
// - Runs a multi-cycle incremental win check around the last written cell; streams cells out for display.
// PARAMETERS
// - N   3  board dimension, legal 3..8
// - K   3  stones in a row needed to win, legal 3..N
// - RW  $clog2(N)  row/col index width, derived, not overridden
// PORTS
// - clk            in   1     single system clock, all state updates on rising edge
// - reset          in   1     synchronous, active-high; clears board, turn, win, FSM, scan counter
// - clear          in   1     synchronous new-game; same as reset except scan counter keeps running
// - move_valid     in   1     move offered this cycle
// - move_ready     out  1     engine can accept a move this cycle
// - move_player    in   2     2'b10 = X, 2'b01 = O; 2'b00 and 2'b11 are illegal
// - move_row       in   RW    target row
// - move_col       in   RW    target column
// - resp_valid     out  1     one-cycle pulse, response to the accepted move
// - resp_err       out  3     error code, valid while resp_valid is high
// - win            out  2     2'b10 X won, 2'b01 O won, 2'b11 tie, 2'b00 game in progress
// - turn           out  2     player due to move next, same encoding as move_player
// - scan_row       out  RW    display scan row
// - scan_col       out  RW    display scan column
// - scan_cell      out  2     contents of (scan_row, scan_col)
// BEHAVIOUR
// - Reset values: board all 2'b00, turn = X, win = 0, move_ready = 1, resp_valid = 0, resp_err = 0.
//   Scan position resets to (0,0). reset overrides clear, clear overrides every other input.
// - Accept: move_valid & move_ready at a rising edge. Response appears on the next cycle as resp_valid = 1.
// - Error codes, in priority order:
//   - 4 GAMEOVER: win != 0
//   - 1 PARSE: illegal player, or row/col >= N
//   - 2 TURN: move_player != turn
//   - 3 OCCUPIED: cell != 0
//   - 0 OK
// - Rejected move: board and turn are unchanged, and move_ready stays high.
// - OK move: the cell is written at the accepting edge, turn toggles, and the FSM leaves IDLE.
// - FSM: IDLE -> CHK_H -> CHK_V -> CHK_D -> CHK_A -> IDLE; one direction is evaluated per cycle.
//   - Directions: horizontal, vertical, diagonal, anti-diagonal.
//   - move_ready = (state == IDLE).
// - Direction check: run = 1 + contiguous same-player cells on each side of the written cell.
//   - At most K-1 cells are counted per side; counting stops at the board edge.
//   - Any run >= K sets a sticky win flag for that player.
// - Win update: win updates on the edge leaving CHK_A, so a winning move sees win != 0 four cycles after resp_valid.
//   - Tie = 2'b11 when move count == N*N and no win.
//   - The move counter is $clog2(N*N+1) bits wide.
// - Latency: accept at edge t; resp_valid in cycle t+1; CHK_H..CHK_A in cycles t+1..t+4; win and move_ready valid at t+5.
// - win holds until reset or clear. While win != 0, every offered move gets GAMEOVER and the board never changes.
// - clear during a CHK_* state aborts the check and returns to IDLE with the board empty; no resp_valid is produced.
// - Scan: row-major counter advances one cell per cycle and wraps (N-1,N-1) -> (0,0).
//   - scan_cell is registered board content, so a write is visible from the cycle after the write.
// PARAMETER / STRUCTURE
// - Shared package tictactoe_pkg holds:
//   - player_t constants (EMPTY 2'b00, X 2'b10, O 2'b01, TIE 2'b11)
//   - err_t enum (OK, PARSE, TURN, OCCUPIED, GAMEOVER)
//   - state_t enum (IDLE, CHK_H, CHK_V, CHK_D, CHK_A)
// - One sub-module, line_counter #(N,K): given board, origin, direction step and player, returns run >= K.
//   It is instantiated once and muxed by state.
// - Board storage: 2*N*N-bit register with synchronous reset/clear.
// TESTING
// - N=3,K=3: X(0,0), O(1,1), X(0,1), O(2,2), X(0,2) -> resp_err 0 each time; win = 2'b10 exactly 4 cycles after the 5th resp_valid.
// - N=3: O moves first after reset -> resp_err 2, turn stays X; X to (3,0) -> resp_err 1; X to occupied (0,0) -> resp_err 3.
// - N=3: nine-move draw sequence -> win = 2'b11 after the final check; a 10th move -> resp_err 4, board unchanged.
// - N=5,K=4: O anti-diagonal (0,4),(1,3),(2,2),(3,1) -> win = 2'b01; any 3-in-a-row prefix -> win stays 0.
// - N=3: assert clear in cycle CHK_D of a winning move -> win = 0, board empty, move_ready = 1 next cycle.
// - Scan: after reset, scan position visits (0,0)..(N-1,N-1) in N*N cycles, then wraps; a written cell appears on scan_cell.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the N x N board engine.
//   player_t : 2-bit cell/player code (EMPTY, X, O, TIE)
//   err_t    : per-move response code, lower value = accepted move
//   state_t  : win-check sequencer states
package tictactoe_pkg;

  typedef logic [1:0] player_t;

  localparam player_t EMPTY = 2'b00;
  localparam player_t X     = 2'b10;
  localparam player_t O     = 2'b01;
  localparam player_t TIE   = 2'b11;

  typedef enum logic [2:0] {
    OK       = 3'd0,
    PARSE    = 3'd1,
    TURN     = 3'd2,
    OCCUPIED = 3'd3,
    GAMEOVER = 3'd4
  } err_t;

  typedef enum logic [2:0] {
    IDLE,
    CHK_H,
    CHK_V,
    CHK_D,
    CHK_A
  } state_t;

  function automatic logic legal_player(input player_t p);
    return (p == X) || (p == O);
  endfunction

endpackage

// File: rtl/line_counter.sv
// Combinational run detector for one direction through one cell.
//   board   : packed board, cell (r,c) at bits [2*(r*N+c) +: 2]
//   row/col : origin cell (the cell just written)
//   step_r/step_c : signed direction step, each -1, 0 or +1
//   player  : stone colour to count
//   hit     : 1 when the run through the origin reaches K
module line_counter
  import tictactoe_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3,
  localparam int RW = $clog2(N)
) (
  input  logic [2*N*N-1:0] board,
  input  logic [RW-1:0]    row,
  input  logic [RW-1:0]    col,
  input  logic signed [1:0] step_r,
  input  logic signed [1:0] step_c,
  input  player_t          player,
  output logic             hit
);

  // Off-board positions read as EMPTY, which ends the run at the edge.
  function automatic player_t cell_at(input logic [2*N*N-1:0] b, input int r, input int c);
    if (r < 0 || r >= N || c < 0 || c >= N) return EMPTY;
    return b[2*(r*N+c) +: 2];
  endfunction

  int   run_len;
  int   rr;
  int   cc;
  logic cont;

  // The origin counts as one; each side adds at most K-1 contiguous stones.
  always_comb begin
    run_len = 1;
    rr      = 0;
    cc      = 0;
    cont    = 1'b0;
    for (int s = 0; s < 2; s++) begin
      cont = 1'b1;
      for (int i = 1; i < K; i++) begin
        rr = int'(row) + ((s == 0) ? i : -i) * int'(step_r);
        cc = int'(col) + ((s == 0) ? i : -i) * int'(step_c);
        if (cont && cell_at(board, rr, cc) == player) run_len = run_len + 1;
        else cont = 1'b0;
      end
    end
    hit = (run_len >= K);
  end

endmodule

// File: rtl/board_engine.sv
// N x N, K-in-a-row board engine.
//   clk, reset (sync, active-high), clear (sync new game, scan keeps running)
//   move_valid/move_ready/move_player/move_row/move_col : move handshake
//   resp_valid/resp_err : one-cycle response to each accepted move
//   win  : EMPTY in play, X or O winner, TIE on a full board
//   turn : player due to move next
//   scan_row/scan_col/scan_cell : free-running row-major display scan
//
// state | meaning
// IDLE  | waiting for a move, move_ready high
// CHK_H | checking horizontal run through last cell
// CHK_V | checking vertical run
// CHK_D | checking diagonal run
// CHK_A | checking anti-diagonal run, win updates on exit
module board_engine
  import tictactoe_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3,
  localparam int RW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          move_valid,
  output logic          move_ready,
  input  logic [1:0]    move_player,
  input  logic [RW-1:0] move_row,
  input  logic [RW-1:0] move_col,
  output logic          resp_valid,
  output logic [2:0]    resp_err,
  output logic [1:0]    win,
  output logic [1:0]    turn,
  output logic [RW-1:0] scan_row,
  output logic [RW-1:0] scan_col,
  output logic [1:0]    scan_cell
);

  localparam int CW    = $clog2(N*N+1);
  localparam int CELLS = N*N;

  state_t            state, state_nxt;
  logic [2*N*N-1:0]  board;
  logic [RW-1:0]     last_row, last_col;
  player_t           last_player;
  logic              found;
  logic [CW-1:0]     mcount;

  logic              in_range;
  int                cell_idx;
  player_t           target;
  err_t              err;
  logic              accept;
  logic              ok_move;
  logic signed [1:0] step_r, step_c;
  logic              hit;

  assign move_ready = (state == IDLE);
  assign accept     = move_valid && move_ready;
  assign ok_move    = accept && (err == OK);

  // Out-of-range coordinates fall back to cell 0 so the read stays in bounds;
  // PARSE outranks OCCUPIED, so that value is never used.
  always_comb begin
    in_range = (int'(move_row) < N) && (int'(move_col) < N);
    cell_idx = in_range ? int'(move_row) * N + int'(move_col) : 0;
    target   = board[2*cell_idx +: 2];
    if (win != EMPTY)                                  err = GAMEOVER;
    else if (!legal_player(move_player) || !in_range)  err = PARSE;
    else if (move_player != turn)                      err = TURN;
    else if (target != EMPTY)                          err = OCCUPIED;
    else                                               err = OK;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    step_r    = 2'sd0;
    step_c    = 2'sd1;
    case (state)
      IDLE:  if (ok_move) state_nxt = CHK_H;
      CHK_H: state_nxt = CHK_V;
      CHK_V: begin state_nxt = CHK_D; step_r = 2'sd1; step_c = 2'sd0;  end
      CHK_D: begin state_nxt = CHK_A; step_r = 2'sd1; step_c = 2'sd1;  end
      CHK_A: begin state_nxt = IDLE;  step_r = 2'sd1; step_c = 2'sb11; end
      default: state_nxt = IDLE;
    endcase
  end

  line_counter #(.N(N), .K(K)) u_line (
    .board  (board),
    .row    (last_row),
    .col    (last_col),
    .step_r (step_r),
    .step_c (step_c),
    .player (last_player),
    .hit    (hit)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      board       <= '0;
      turn        <= X;
      win         <= EMPTY;
      mcount      <= '0;
      found       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_err    <= OK;
      last_row    <= '0;
      last_col    <= '0;
      last_player <= EMPTY;
    end else begin
      resp_valid <= accept;
      if (accept) resp_err <= err;
      if (ok_move) begin
        board[2*cell_idx +: 2] <= move_player;
        turn        <= (turn == X) ? O : X;
        mcount      <= mcount + 1'b1;
        last_row    <= move_row;
        last_col    <= move_col;
        last_player <= move_player;
        found       <= 1'b0;
      end
      if (state != IDLE) found <= found | hit;
      // hit is folded in directly so the anti-diagonal result counts this cycle.
      if (state == CHK_A) begin
        if (found || hit)              win <= last_player;
        else if (int'(mcount) == CELLS) win <= TIE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_row <= '0;
      scan_col <= '0;
    end else if (int'(scan_col) == N-1) begin
      scan_col <= '0;
      scan_row <= (int'(scan_row) == N-1) ? '0 : scan_row + 1'b1;
    end else begin
      scan_col <= scan_col + 1'b1;
    end
  end

  assign scan_cell = board[2*(int'(scan_row)*N + int'(scan_col)) +: 2];

endmodule

// File: tb/tb_board_engine.sv
module tb_board_engine;
  import tictactoe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clr3, clr5;
  logic       mv3, mv5;
  logic [1:0] mp3, mp5;
  logic [1:0] mr3, mc3;
  logic [2:0] mr5, mc5;
  logic       rdy3, rdy5, rv3, rv5;
  logic [2:0] re3, re5;
  logic [1:0] win3, win5, turn3, turn5, scell3, scell5;
  logic [1:0] sr3, sc3;
  logic [2:0] sr5, sc5;

  int n_assert = 0;
  int n_fail   = 0;
  logic [2:0] sb[$];
  logic [1:0] mb3 [0:8];
  logic [1:0] mt3, mt5;

  board_engine #(.N(3), .K(3)) dut3 (
    .clk(clk), .reset(rst), .clear(clr3), .move_valid(mv3), .move_ready(rdy3),
    .move_player(mp3), .move_row(mr3), .move_col(mc3), .resp_valid(rv3),
    .resp_err(re3), .win(win3), .turn(turn3), .scan_row(sr3), .scan_col(sc3),
    .scan_cell(scell3)
  );

  board_engine #(.N(5), .K(4)) dut5 (
    .clk(clk), .reset(rst), .clear(clr5), .move_valid(mv5), .move_ready(rdy5),
    .move_player(mp5), .move_row(mr5), .move_col(mc5), .resp_valid(rv5),
    .resp_err(re5), .win(win5), .turn(turn5), .scan_row(sr5), .scan_col(sc5),
    .scan_cell(scell5)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int sel);
    logic r;
    for (int i = 0; i < 20; i++) begin
      r = (sel == 3) ? rdy3 : rdy5;
      if (r === 1'b1) break;
      tick();
    end
    r = (sel == 3) ? rdy3 : rdy5;
    chk("ready_wait", r, 1);
  endtask

  task automatic move(input int sel, input logic [1:0] p, input int r, input int c,
                      input logic [2:0] exp);
    logic       v;
    logic [2:0] got, e;
    logic [1:0] t;
    wait_ready(sel);
    if (sel == 3) begin mv3 = 1'b1; mp3 = p; mr3 = r[1:0]; mc3 = c[1:0]; end
    else          begin mv5 = 1'b1; mp5 = p; mr5 = r[2:0]; mc5 = c[2:0]; end
    sb.push_back(exp);
    if (exp == OK) begin
      if (sel == 3) begin mb3[r*3+c] = p; mt3 = (mt3 == X) ? O : X; end
      else          mt5 = (mt5 == X) ? O : X;
    end
    tick();
    mv3 = 1'b0;
    mv5 = 1'b0;
    v   = (sel == 3) ? rv3 : rv5;
    got = (sel == 3) ? re3 : re5;
    t   = (sel == 3) ? turn3 : turn5;
    chk("resp_valid", v, 1);
    if (v === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("resp_err", got, e);
    end
    chk("turn", t, (sel == 3) ? mt3 : mt5);
    if (exp != OK) chk("ready_after_reject", (sel == 3) ? rdy3 : rdy5, 1);
  endtask

  // Compares scan_cell with the model board and the scan step for 10 cycles.
  task automatic scan_check3();
    logic [7:0] prev, cur;
    prev = sr3 * 3 + sc3;
    chk("scan_pos_valid", prev < 9, 1);
    if (prev < 9) chk("scan_cell", scell3, mb3[prev[3:0]]);
    for (int i = 0; i < 10; i++) begin
      tick();
      cur = sr3 * 3 + sc3;
      chk("scan_step", cur, (prev + 1) % 9);
      if (cur < 9) chk("scan_cell", scell3, mb3[cur[3:0]]);
      prev = cur;
    end
  endtask

  task automatic clear3();
    clr3 = 1'b1;
    tick();
    clr3 = 1'b0;
    for (int i = 0; i < 9; i++) mb3[i] = EMPTY;
    mt3 = X;
    chk("clear_win", win3, 0);
    chk("clear_turn", turn3, X);
    chk("clear_ready", rdy3, 1);
  endtask

  initial begin
    logic [7:0] p3, p5;
    rst = 1'b1; clr3 = 1'b0; clr5 = 1'b0;
    mv3 = 1'b0; mv5 = 1'b0; mp3 = '0; mp5 = '0;
    mr3 = '0; mc3 = '0; mr5 = '0; mc5 = '0;
    mt3 = X; mt5 = X;
    for (int i = 0; i < 9; i++) mb3[i] = EMPTY;
    repeat (3) tick();

    chk("rst_ready", rdy3, 1);
    chk("rst_resp_valid", rv3, 0);
    chk("rst_resp_err", re3, 0);
    chk("rst_win", win3, 0);
    chk("rst_turn", turn3, X);
    chk("rst_scan_row", sr3, 0);
    chk("rst_scan_col", sc3, 0);
    chk("rst_scan_cell", scell3, 0);
    chk("rst_win5", win5, 0);
    chk("rst_turn5", turn5, X);
    rst = 1'b0;

    for (int k = 1; k <= 26; k++) begin
      tick();
      p3 = sr3 * 3 + sc3;
      p5 = sr5 * 5 + sc5;
      chk("scan3_idx", p3, k % 9);
      chk("scan5_idx", p5, k % 25);
    end

    // Error codes and a row-0 win for X
    move(3, O,     0, 0, TURN);
    move(3, X,     3, 0, PARSE);
    move(3, 2'b11, 0, 0, PARSE);
    move(3, 2'b00, 1, 1, PARSE);
    move(3, X,     0, 0, OK);
    move(3, O,     0, 0, OCCUPIED);
    move(3, O,     1, 1, OK);
    move(3, X,     0, 1, OK);
    move(3, O,     2, 2, OK);
    move(3, X,     0, 2, OK);
    chk("win_t1", win3, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("win_early", win3, 0);
    end
    tick();
    chk("win_x", win3, X);
    chk("ready_after_win", rdy3, 1);
    move(3, O, 1, 0, GAMEOVER);
    move(3, O, 3, 3, GAMEOVER);
    scan_check3();

    // Full-board draw
    clear3();
    move(3, X, 0, 0, OK);
    move(3, O, 0, 2, OK);
    move(3, X, 0, 1, OK);
    move(3, O, 1, 0, OK);
    move(3, X, 1, 2, OK);
    move(3, O, 1, 1, OK);
    move(3, X, 2, 0, OK);
    move(3, O, 2, 1, OK);
    move(3, X, 2, 2, OK);
    wait_ready(3);
    chk("win_tie", win3, TIE);
    move(3, O, 0, 0, GAMEOVER);
    scan_check3();

    // clear while CHK_D is running a winning check
    clear3();
    move(3, X, 0, 0, OK);
    move(3, O, 1, 0, OK);
    move(3, X, 0, 1, OK);
    move(3, O, 1, 1, OK);
    move(3, X, 0, 2, OK);
    tick();
    tick();
    clr3 = 1'b1;
    tick();
    clr3 = 1'b0;
    for (int i = 0; i < 9; i++) mb3[i] = EMPTY;
    mt3 = X;
    chk("abort_win", win3, 0);
    chk("abort_ready", rdy3, 1);
    chk("abort_resp_valid", rv3, 0);
    chk("abort_turn", turn3, X);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_win_hold", win3, 0);
    end
    scan_check3();
    move(3, X, 1, 1, OK);
    scan_check3();

    // N=5, K=4 anti-diagonal win for O
    move(5, X, 5, 0, PARSE);
    move(5, X, 0, 0, OK);
    move(5, O, 0, 4, OK);
    move(5, X, 2, 0, OK);
    move(5, O, 1, 3, OK);
    move(5, X, 4, 4, OK);
    move(5, O, 2, 2, OK);
    wait_ready(5);
    chk("win5_prefix", win5, 0);
    move(5, X, 4, 2, OK);
    wait_ready(5);
    chk("win5_prefix2", win5, 0);
    move(5, O, 3, 1, OK);
    wait_ready(5);
    chk("win5_o", win5, O);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
